// File: rtl/uarch_pkg.sv
// Shared micro-architecture types: writeback packet format, CDB sizing and FU source indices.
package uarch_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned TAG_W         = 6;
    localparam int unsigned NUM_FU_SRC    = 4;
    localparam int unsigned NUM_CDB_PORTS = 2;

    localparam int unsigned FU_ALU0 = 0;
    localparam int unsigned FU_ALU1 = 1;
    localparam int unsigned FU_MDU  = 2;
    localparam int unsigned FU_LSU  = 3;

    typedef struct packed {
        logic             is_valid;
        logic [TAG_W-1:0] dest_tag;
        logic [XLEN-1:0]  result;
    } writeback_packet_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU writeback / CDB broadcast bundle; master = FU side, slave = arbiter side.
interface cdb_arbiter_if
    import uarch_pkg::*;
#(
    parameter int unsigned NUM_SRC = NUM_FU_SRC,
    parameter int unsigned NUM_CDB = NUM_CDB_PORTS
) ();

    writeback_packet_t [NUM_SRC-1:0] fu_result;
    logic              [NUM_SRC-1:0] fu_cdb_gnt;
    writeback_packet_t [NUM_CDB-1:0] cdb_out;

    modport master (output fu_result, input fu_cdb_gnt, input cdb_out);
    modport slave  (input fu_result, output fu_cdb_gnt, output cdb_out);

endinterface

// File: rtl/cdb_rr_picker.sv
// Combinational round-robin picker: first NUM_CDB requesters scanning cyclically from i_ptr.
module cdb_rr_picker #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned NUM_CDB = 2,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_SRC-1:0]               i_req,
    input  logic [PTR_W-1:0]                 i_ptr,
    output logic [NUM_CDB-1:0][NUM_SRC-1:0]  o_lane_sel,
    output logic [NUM_CDB-1:0]               o_lane_vld,
    output logic [NUM_SRC-1:0]               o_gnt,
    output logic [PTR_W-1:0]                 o_next_ptr
);

    always_comb begin
        int unsigned w_n;
        int unsigned w_idx;
        o_lane_sel = '0;
        o_lane_vld = '0;
        o_gnt      = '0;
        o_next_ptr = i_ptr;
        w_n        = 0;
        for (int unsigned off = 0; off < NUM_SRC; off++) begin
            // explicit wrap so NUM_SRC need not be a power of two
            w_idx = int'(i_ptr) + off;
            if (w_idx >= NUM_SRC) w_idx = w_idx - NUM_SRC;
            if (i_req[w_idx] && (w_n < NUM_CDB)) begin
                o_lane_sel[w_n][w_idx] = 1'b1;
                o_lane_vld[w_n]        = 1'b1;
                o_gnt[w_idx]           = 1'b1;
                o_next_ptr = (w_idx + 1 == NUM_SRC) ? '0 : PTR_W'(w_idx + 1);
                w_n = w_n + 1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants up to NUM_CDB FU results per cycle onto registered lanes.
module cdb_arbiter
    import uarch_pkg::*;
#(
    parameter int unsigned NUM_SRC = NUM_FU_SRC,
    parameter int unsigned NUM_CDB = NUM_CDB_PORTS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    cdb_arbiter_if.slave  wb
);

    localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PTR_W-1:0]                 r_rr_ptr;
    writeback_packet_t [NUM_CDB-1:0]  r_cdb_out;
    logic [NUM_SRC-1:0]               w_req;
    logic [NUM_SRC-1:0]               w_gnt;
    logic [NUM_CDB-1:0][NUM_SRC-1:0]  w_lane_sel;
    logic [NUM_CDB-1:0]               w_lane_vld;
    logic [PTR_W-1:0]                 w_next_ptr;
    writeback_packet_t [NUM_CDB-1:0]  w_lane_pkt;

    // flush masks requests up front, so gnt is zero and the pointer holds
    always_comb begin
        w_req = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++)
            w_req[i] = wb.fu_result[i].is_valid & ~flush;
    end

    cdb_rr_picker #(
        .NUM_SRC (NUM_SRC),
        .NUM_CDB (NUM_CDB),
        .PTR_W   (PTR_W)
    ) u_picker (
        .i_req      (w_req),
        .i_ptr      (r_rr_ptr),
        .o_lane_sel (w_lane_sel),
        .o_lane_vld (w_lane_vld),
        .o_gnt      (w_gnt),
        .o_next_ptr (w_next_ptr)
    );

    always_comb begin
        w_lane_pkt = '0;
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
            for (int unsigned i = 0; i < NUM_SRC; i++)
                if (w_lane_sel[k][i]) w_lane_pkt[k] = w_lane_pkt[k] | wb.fu_result[i];
            w_lane_pkt[k].is_valid = w_lane_vld[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cdb_out <= '0;
            r_rr_ptr  <= '0;
        end else if (flush) begin
            r_cdb_out <= '0;
        end else begin
            r_cdb_out <= w_lane_pkt;
            r_rr_ptr  <= w_next_ptr;
        end
    end

    assign wb.fu_cdb_gnt = rst ? w_gnt : '0;
    assign wb.cdb_out    = r_cdb_out;

endmodule
